// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register with a skid slot, stall/flush control and a registered in_ready.
// Optional performance counters (stall_cnt, flush_cnt) are built only when PIPE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int FIELDS = 6,
  parameter int DATA_W = 32,
  localparam int PW    = FIELDS * DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
`ifdef PIPE_PERF_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt
`endif
);

  logic          main_v_q, main_v_d;
  logic          skid_v_q, skid_v_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_ready_q;
  logic          in_xfer, out_xfer;

  // in_ready_q mirrors !skid_v_q, so an accepted word always has the skid slot free.
  assign in_xfer   = in_valid && in_ready_q && !stall && !flush;
  assign out_valid = main_v_q && !stall;
  assign out_xfer  = out_valid && out_ready;
  assign in_ready  = in_ready_q && !stall;
  assign out_data  = main_v_q ? main_q : '0;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = '0;
      skid_d   = '0;
    end else if (!stall) begin
      if (!main_v_q || out_xfer) begin
        if (skid_v_q) begin
          main_v_d = 1'b1;
          main_d   = skid_q;
          skid_v_d = 1'b0;
          skid_d   = '0;
        end else if (in_xfer) begin
          main_v_d = 1'b1;
          main_d   = in_data;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (in_xfer) begin
        skid_v_d = 1'b1;
        skid_d   = in_data;
      end
    end
  end

  // NOTE: payload registers are reset too, because out_data must read zero while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= !skid_v_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic stall_evt, flush_evt;
  assign stall_evt = stall || (out_valid && !out_ready);
  assign flush_evt = flush && (main_v_q || skid_v_q);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush_evt && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
